// File: rtl/sound_voice_alloc.sv
// Allocates the four mixer channels among edge-detected sound triggers.
// Handles priority, retrigger, stealing and looping sounds, and issues start/stop pulses.

module sound_voice_chan #(
    parameter int IDW = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           set,
    input  logic           clr,
    input  logic           done,
    input  logic [IDW-1:0] wid,
    output logic           valid,
    output logic [IDW-1:0] id
);
    // An allocator write overrides the player's end-of-sample clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            id    <= '0;
        end else if (set) begin
            valid <= 1'b1;
            id    <= wid;
        end else if (clr || done) begin
            valid <= 1'b0;
        end
    end
endmodule

module sound_voice_alloc #(
    parameter int              NREQ      = 8,
    parameter int              NCH       = 4,
    parameter int              IDW       = 3,
    parameter logic [NREQ-1:0] LOOP_MASK = {{(NREQ-1){1'b0}}, 1'b1}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     trig,
    input  logic [NCH-1:0]      ch_done,
    output logic [NCH-1:0]      ch_start,
    output logic [NCH-1:0]      ch_stop,
    output logic [NCH*IDW-1:0]  ch_id,
    output logic [NCH-1:0]      ch_active,
    output logic [7:0]          drop_cnt,
    output logic                busy
);
    localparam int CW = $clog2(NCH);

    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state, state_n;

    logic [NREQ-1:0]          trig_d, start_pend, stop_pend;
    logic [NREQ-1:0]          start_set, start_clr, stop_clr;
    logic [NCH-1:0]           valid, wr_set, wr_clr;
    logic [NCH-1:0][IDW-1:0]  id;
    logic [IDW-1:0]           rid_q, s_idx, r_idx, max_id;
    logic [CW-1:0]            tgt_q, tgt, stop_ch, own_ch, free_ch, steal_ch;
    logic                     stop_hit, own_hit, free_hit, steal_ok;
    logic                     take_stop, take_start, grant;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        sound_voice_chan #(.IDW(IDW)) u_chan (
            .clk   (clk),
            .reset (reset),
            .set   (wr_set[c]),
            .clr   (wr_clr[c]),
            .done  (ch_done[c]),
            .wid   (rid_q),
            .valid (valid[c]),
            .id    (id[c])
        );
        assign ch_id[c*IDW +: IDW] = id[c];
        assign wr_set[c] = (state == ISSUE) && (tgt_q == CW'(c));
        assign wr_clr[c] = take_stop && stop_hit && (stop_ch == CW'(c));
    end

    assign ch_active = valid;
    assign busy      = (state != IDLE) || (|start_pend) || (|stop_pend);

    // Rising edges plus restarts of looping sounds whose trigger is still held.
    always_comb begin
        start_set = trig & ~trig_d;
        for (int c = 0; c < NCH; c++)
            if (ch_done[c] && valid[c] && !wr_set[c] && LOOP_MASK[id[c]] && trig[id[c]])
                start_set[id[c]] = 1'b1;
    end

    always_comb begin
        s_idx = '0;
        r_idx = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (stop_pend[i])  s_idx = IDW'(i);
            if (start_pend[i]) r_idx = IDW'(i);
        end
        stop_hit = 1'b0; stop_ch = '0;
        own_hit  = 1'b0; own_ch  = '0;
        free_hit = 1'b0; free_ch = '0;
        for (int c = NCH-1; c >= 0; c--) begin
            if (valid[c] && id[c] == s_idx) begin stop_hit = 1'b1; stop_ch = CW'(c); end
            if (valid[c] && id[c] == r_idx) begin own_hit  = 1'b1; own_ch  = CW'(c); end
            if (!valid[c])                  begin free_hit = 1'b1; free_ch = CW'(c); end
        end
        // Steal victim: lowest-priority owner; ties resolve to the lowest channel.
        max_id   = id[0];
        steal_ch = '0;
        for (int c = 1; c < NCH; c++)
            if (id[c] > max_id) begin max_id = id[c]; steal_ch = CW'(c); end
        steal_ok = max_id > r_idx;
        tgt = own_hit ? own_ch : (free_hit ? free_ch : steal_ch);
    end

    always_comb begin
        state_n    = state;
        take_stop  = 1'b0;
        take_start = 1'b0;
        grant      = 1'b0;
        start_clr  = '0;
        stop_clr   = '0;
        case (state)
            IDLE: begin
                if (|stop_pend) begin
                    take_stop       = 1'b1;
                    stop_clr[s_idx] = 1'b1;
                end else if (|start_pend) begin
                    take_start       = 1'b1;
                    start_clr[r_idx] = 1'b1;
                    if (own_hit || free_hit || steal_ok) begin
                        grant   = 1'b1;
                        state_n = ISSUE;
                    end
                end
            end
            ISSUE: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            trig_d     <= '0;
            start_pend <= '0;
            stop_pend  <= '0;
            tgt_q      <= '0;
            rid_q      <= '0;
            ch_start   <= '0;
            ch_stop    <= '0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_n;
            trig_d     <= trig;
            start_pend <= (start_pend & ~start_clr) | start_set;
            stop_pend  <= (stop_pend & ~stop_clr) | (~trig & trig_d & LOOP_MASK);
            if (grant) begin
                tgt_q <= tgt;
                rid_q <= r_idx;
            end
            ch_start <= wr_set;
            ch_stop  <= wr_clr;
            if (take_start && !grant && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_sound_voice_alloc.sv
// Directed bench for sound_voice_alloc: grants, stealing, looping sounds, drops.

module tb_sound_voice_alloc;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  trig;
    logic [3:0]  ch_done;
    logic [3:0]  ch_start, ch_stop, ch_active;
    logic [11:0] ch_id;
    logic [7:0]  drop_cnt;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    sound_voice_alloc dut (
        .clk(clk), .reset(reset), .trig(trig), .ch_done(ch_done),
        .ch_start(ch_start), .ch_stop(ch_stop), .ch_id(ch_id),
        .ch_active(ch_active), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        reset = 1'b1; trig = 8'h00; ch_done = 4'h0;
        tick; tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b1; trig = 8'hFF; ch_done = 4'h0;
        tick; tick;
        checks++; if ({ch_start, ch_stop, ch_active} !== 12'h000) begin errors++; $display("FAIL reset_pulses: got %h exp 000", {ch_start, ch_stop, ch_active}); end
        checks++; if (ch_id !== 12'h000) begin errors++; $display("FAIL reset_id: got %h exp 000", ch_id); end
        checks++; if ({drop_cnt, busy} !== 9'h000) begin errors++; $display("FAIL reset_cnt_busy: got %h exp 000", {drop_cnt, busy}); end
        reset = 1'b0;
        #1;
        checks++; if ({ch_start, ch_stop, busy} !== 9'h000) begin errors++; $display("FAIL reset_release: got %h exp 000", {ch_start, ch_stop, busy}); end
    endtask

    task automatic test_single;
        reset_dut;
        trig = 8'h08;
        tick; tick;
        checks++; if (ch_start !== 4'b0000) begin errors++; $display("FAIL single_early: got %b exp 0000", ch_start); end
        tick;
        checks++; if (ch_start !== 4'b0001) begin errors++; $display("FAIL single_start: got %b exp 0001", ch_start); end
        checks++; if (ch_id[2:0] !== 3'd3) begin errors++; $display("FAIL single_id: got %0d exp 3", ch_id[2:0]); end
        checks++; if (ch_active !== 4'b0001) begin errors++; $display("FAIL single_active: got %b exp 0001", ch_active); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b exp 0", busy); end
        tick;
        checks++; if (ch_start !== 4'b0000) begin errors++; $display("FAIL single_one_cycle: got %b exp 0000", ch_start); end
        ch_done = 4'b0001;
        tick;
        ch_done = 4'b0000;
        checks++; if (ch_active !== 4'b0000) begin errors++; $display("FAIL single_done: got %b exp 0000", ch_active); end
        tick;
        checks++; if (ch_start !== 4'b0000) begin errors++; $display("FAIL single_no_restart: got %b exp 0000", ch_start); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_start;
        reset_dut;
        trig = 8'h1E;
        tick;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++; if (ch_start !== 4'b0000) begin errors++; $display("FAIL b2b_gap%0d: got %b exp 0000", k, ch_start); end
            tick;
            exp_start = 4'b0001 << k;
            checks++; if (ch_start !== exp_start) begin errors++; $display("FAIL b2b_start%0d: got %b exp %b", k, ch_start, exp_start); end
            checks++; if (ch_id[k*3 +: 3] !== 3'(k+1)) begin errors++; $display("FAIL b2b_id%0d: got %0d exp %0d", k, ch_id[k*3 +: 3], k+1); end
        end
        checks++; if (ch_active !== 4'hF) begin errors++; $display("FAIL b2b_active: got %h exp F", ch_active); end
    endtask

    task automatic test_steal_drop;
        reset_dut;
        trig = 8'hF0;
        tick;
        for (int k = 0; k < 8; k++) tick;
        checks++; if (ch_id !== 12'o7654) begin errors++; $display("FAIL steal_setup: got %o exp 7654", ch_id); end
        trig = 8'hF4;
        tick; tick; tick;
        checks++; if (ch_start !== 4'b1000) begin errors++; $display("FAIL steal_start: got %b exp 1000", ch_start); end
        checks++; if (ch_id[11:9] !== 3'd2) begin errors++; $display("FAIL steal_id: got %0d exp 2", ch_id[11:9]); end
        checks++; if (ch_stop !== 4'b0000) begin errors++; $display("FAIL steal_nostop: got %b exp 0000", ch_stop); end
        trig = 8'h74;
        tick;
        trig = 8'hF4;
        tick; tick;
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_one: got %0d exp 1", drop_cnt); end
        tick;
        checks++; if ({ch_start, ch_stop} !== 8'h00) begin errors++; $display("FAIL drop_nopulse: got %h exp 00", {ch_start, ch_stop}); end
        checks++; if (ch_id !== 12'o2654) begin errors++; $display("FAIL drop_table: got %o exp 2654", ch_id); end
    endtask

    task automatic test_loop;
        reset_dut;
        trig = 8'h01;
        tick; tick; tick;
        checks++; if ({ch_start, ch_active} !== 8'h11) begin errors++; $display("FAIL loop_grant: got %h exp 11", {ch_start, ch_active}); end
        tick;
        ch_done = 4'b0001;
        tick;
        ch_done = 4'b0000;
        checks++; if (ch_active !== 4'b0000) begin errors++; $display("FAIL loop_done_clear: got %b exp 0000", ch_active); end
        tick; tick;
        checks++; if (ch_start !== 4'b0001) begin errors++; $display("FAIL loop_restart: got %b exp 0001", ch_start); end
        checks++; if (ch_active !== 4'b0001) begin errors++; $display("FAIL loop_restart_active: got %b exp 0001", ch_active); end
        tick;
        trig = 8'h00;
        tick;
        checks++; if (ch_stop !== 4'b0000) begin errors++; $display("FAIL loop_stop_early: got %b exp 0000", ch_stop); end
        tick;
        checks++; if (ch_stop !== 4'b0001) begin errors++; $display("FAIL loop_stop: got %b exp 0001", ch_stop); end
        checks++; if (ch_active !== 4'b0000) begin errors++; $display("FAIL loop_stop_active: got %b exp 0000", ch_active); end
        tick;
        checks++; if ({ch_stop, busy} !== 5'b00000) begin errors++; $display("FAIL loop_stop_once: got %b exp 00000", {ch_stop, busy}); end
    endtask

    task automatic test_retrigger;
        reset_dut;
        trig = 8'h0A;
        tick;
        for (int k = 0; k < 4; k++) tick;
        checks++; if (ch_id[5:0] !== 6'o31) begin errors++; $display("FAIL retrig_setup: got %o exp 31", ch_id[5:0]); end
        ch_done = 4'b0001;
        tick;
        ch_done = 4'b0000;
        checks++; if (ch_active !== 4'b0010) begin errors++; $display("FAIL retrig_free0: got %b exp 0010", ch_active); end
        trig = 8'h02;
        tick;
        trig = 8'h0A;
        tick; tick; tick;
        checks++; if (ch_start !== 4'b0010) begin errors++; $display("FAIL retrig_start: got %b exp 0010", ch_start); end
        checks++; if (ch_active !== 4'b0010) begin errors++; $display("FAIL retrig_active: got %b exp 0010", ch_active); end
    endtask

    task automatic test_done_in_issue;
        trig = 8'h02;
        tick;
        trig = 8'h0A;
        tick; tick;
        ch_done = 4'b0010;
        tick;
        ch_done = 4'b0000;
        checks++; if (ch_start !== 4'b0010) begin errors++; $display("FAIL issue_done_start: got %b exp 0010", ch_start); end
        checks++; if (ch_active !== 4'b0010) begin errors++; $display("FAIL issue_done_active: got %b exp 0010", ch_active); end
        tick;
        checks++; if (ch_active !== 4'b0010) begin errors++; $display("FAIL issue_done_hold: got %b exp 0010", ch_active); end
    endtask

    task automatic test_reset_mid_issue;
        reset_dut;
        trig = 8'h04;
        tick; tick;
        #2;
        reset = 1'b1; trig = 8'h00;
        #1;
        checks++; if ({ch_start, ch_active, busy} !== 9'h000) begin errors++; $display("FAIL midreset_clear: got %h exp 000", {ch_start, ch_active, busy}); end
        tick;
        reset = 1'b0;
        tick; tick;
        checks++; if ({ch_start, ch_active, busy} !== 9'h000) begin errors++; $display("FAIL midreset_no_pulse: got %h exp 000", {ch_start, ch_active, busy}); end
    endtask

    task automatic test_drop_saturation;
        reset_dut;
        trig = 8'h0F;
        tick;
        for (int k = 0; k < 8; k++) tick;
        for (int i = 1; i <= 300; i++) begin
            trig = 8'h8F;
            tick;
            trig = 8'h0F;
            tick;
            if (i == 254) begin
                checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL drop_254: got %0d exp 254", drop_cnt); end
            end
            if (i == 255) begin
                checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_255: got %0d exp 255", drop_cnt); end
            end
        end
        tick;
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d exp 255", drop_cnt); end
        checks++; if (ch_id !== 12'o3210) begin errors++; $display("FAIL drop_table: got %o exp 3210", ch_id); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_steal_drop;
        test_loop;
        test_retrigger;
        test_done_in_issue;
        test_reset_mid_issue;
        test_drop_saturation;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
